mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller for the 5-stage 16-bit CPU.
- Sits between the EX/MEM register outputs and the data cache, and produces every input of the MEM/WB pipeline register (ALU result, load data, rd address, WB signals, write enable).
- Sequences load/store handshakes with the data cache.
- Stalls the upstream pipeline on a miss and inserts a WB bubble while waiting.
- Provides a miss counter and a watchdog timeout.

Parameters:
TIMEOUT, 64, WAIT-state cycles before an access is abandoned (2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX/MEM holds a valid instruction
ex_mem_read  in  1  instruction is a load
ex_mem_write  in  1  instruction is a store
ex_alu  in  16  ALU result / memory address
ex_store_data  in  16  store data
ex_rd_addr  in  4  register-file write address
ex_wb_signals  in  3  WB control bits
dc_req  out  1  cache request
dc_we  out  1  cache write (store)
dc_addr  out  16  cache address
dc_wdata  out  16  cache write data
dc_rdata  in  16  cache read data, valid when dc_ready=1
dc_ready  in  1  cache access complete this cycle (same-cycle on hit)
wb_alu  out  16  to MEM/WB alu_in
wb_data  out  16  to MEM/WB data_in
wb_rd_addr  out  4  to MEM/WB rd_addr_in
wb_signals  out  3  to MEM/WB wb_signals_in
wb_we  out  1  to MEM/WB we
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
err  out  1  sticky timeout flag
miss_count  out  16  saturating count of WAIT entries

Behaviour:
- Memory op: mem_op = ex_valid & (ex_mem_read | ex_mem_write). Both read and write set = store.
- States: IDLE, WAIT. wb_we=1 in every cycle; the MEM/WB register always advances.
- IDLE, no mem_op:
  - dc_req=0.
  - wb_alu/wb_rd_addr pass from ex_*; wb_data=0.
  - wb_signals=ex_wb_signals if ex_valid, else 0.
  - mem_stall=0.
- IDLE, mem_op:
  - Combinational drive: dc_req=1, dc_we=ex_mem_write, dc_addr=ex_alu, dc_wdata=ex_store_data.
  - dc_ready=1 (hit): outputs pass as above; wb_data=dc_rdata for a load, 0 for a store. mem_stall=0. Stay IDLE.
  - dc_ready=0 (miss): capture we/addr/wdata/alu/rd/wb into hold registers. wb_signals=0 (bubble), mem_stall=1. Go to WAIT; wait counter=1; miss_count+=1, saturating at 0xFFFF.
- WAIT:
  - dc_req=1, driven from the hold registers; the ex_* inputs are ignored.
  - dc_ready=0: wb_signals=0, mem_stall=1, counter+=1.
  - dc_ready=1: wb_alu/wb_rd_addr/wb_signals from the hold registers. wb_data=dc_rdata for a load, 0 for a store. mem_stall=0. Go to IDLE.
  - counter==TIMEOUT and dc_ready=0: err<=1 (sticky). Complete with wb_signals=0 and wb_data=0, mem_stall=0, dc_req=0 that cycle. Go to IDLE.
- dc_req is the only cache handshake: held high with stable addr/we/wdata until dc_ready is sampled high. Never more than one request outstanding.
- Timing: load-use result reaches the MEM/WB register at the next edge on a hit, and N cycles later on an N-cycle miss.
- Reset (asynchronous, any state, including mid-WAIT):
  - State IDLE; hold registers, counter, err and miss_count = 0.
  - With ex_valid=0 during reset, all outputs are 0 except wb_we=1.
  - The in-flight access is dropped; dc_req falls immediately.

Test Plan:
- Hit load: ex_alu=0x0040, load, rd=5, wb=3'b101, dc_ready=1, dc_rdata=0xBEEF -> same cycle wb_data=0xBEEF, wb_rd_addr=5, wb_signals=101, mem_stall=0, miss_count stays 0.
- 3-cycle miss load: addr=0x1234, dc_ready high on the 3rd WAIT-side cycle, rdata=0x00A5 -> mem_stall=1 for 3 cycles; wb_signals=0 during the stall; then wb_data=0x00A5 with the latched rd/wb; dc_addr=0x1234 held throughout; miss_count=1.
- Store miss: addr=0x0010, data=0x5555, 2-cycle ready -> dc_we=1 and dc_wdata=0x5555 held for 2 cycles; on completion wb_data=0 and wb_signals=the latched value.
- Timeout with TIMEOUT=4 and dc_ready never asserted -> after 4 WAIT cycles err=1, wb_signals=0, FSM returns to IDLE; err remains 1 through later hits.
- Reset mid-WAIT: assert rst 2 cycles into a miss -> dc_req=0, mem_stall=0, miss_count=0 and err=0 immediately, without waiting for a clock edge.
- Saturation: force 65537 misses -> miss_count=0xFFFF.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller for the 5-stage 16-bit CPU.
// Sits between the EX/MEM register and the data cache. It sequences
// load/store handshakes, produces every MEM/WB register input, stalls the
// upstream pipeline while a cache miss is outstanding and abandons an
// access after TIMEOUT wait cycles.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   ex_*                EX/MEM register outputs (valid, read, write, alu/addr,
//                       store data, rd address, WB control bits)
//   dc_req/we/addr/wdata  request to the data cache
//   dc_rdata, dc_ready  cache response (ready same cycle on a hit)
//   wb_*                MEM/WB register inputs (wb_we is always 1)
//   mem_stall           freezes PC, IF/ID, ID/EX and EX/MEM
//   err                 sticky watchdog timeout flag
//   miss_count          saturating count of WAIT entries
module mem_stage_ctrl #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [15:0] ex_alu,
   input  logic [15:0] ex_store_data,
   input  logic [3:0]  ex_rd_addr,
   input  logic [2:0]  ex_wb_signals,
   output logic        dc_req,
   output logic        dc_we,
   output logic [15:0] dc_addr,
   output logic [15:0] dc_wdata,
   input  logic [15:0] dc_rdata,
   input  logic        dc_ready,
   output logic [15:0] wb_alu,
   output logic [15:0] wb_data,
   output logic [3:0]  wb_rd_addr,
   output logic [2:0]  wb_signals,
   output logic        wb_we,
   output logic        mem_stall,
   output logic        err,
   output logic [15:0] miss_count
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state;
   logic        hold_we;
   logic [15:0] hold_addr;
   logic [15:0] hold_wdata;
   logic [3:0]  hold_rd;
   logic [2:0]  hold_wb;
   logic [7:0]  wait_cnt;

   logic mem_op;
   logic timeout;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
   // Watchdog fires in the WAIT cycle whose count reached TIMEOUT without a response.
   assign timeout = (state == WAIT) && !dc_ready && (wait_cnt == TIMEOUT_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hold_we    <= 1'b0;
         hold_addr  <= '0;
         hold_wdata <= '0;
         hold_rd    <= '0;
         hold_wb    <= '0;
         wait_cnt   <= '0;
         err        <= 1'b0;
         miss_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && !dc_ready) begin
                  // Miss: freeze the access so the request stays stable while upstream is stalled.
                  hold_we    <= ex_mem_write;
                  hold_addr  <= ex_alu;
                  hold_wdata <= ex_store_data;
                  hold_rd    <= ex_rd_addr;
                  hold_wb    <= ex_wb_signals;
                  wait_cnt   <= 8'd1;
                  miss_count <= sat_inc16(miss_count);
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (dc_ready) begin
                  state <= IDLE;
               end else if (wait_cnt == TIMEOUT_CNT) begin
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      dc_req     = 1'b0;
      dc_we      = 1'b0;
      dc_addr    = '0;
      dc_wdata   = '0;
      wb_alu     = ex_alu;
      wb_data    = '0;
      wb_rd_addr = ex_rd_addr;
      wb_signals = ex_valid ? ex_wb_signals : 3'b000;
      wb_we      = 1'b1;
      mem_stall  = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               dc_req   = 1'b1;
               dc_we    = ex_mem_write;
               dc_addr  = ex_alu;
               dc_wdata = ex_store_data;
               if (dc_ready) begin
                  wb_data = ex_mem_write ? 16'h0000 : dc_rdata;
               end else begin
                  wb_signals = 3'b000;
                  mem_stall  = 1'b1;
               end
            end
         end
         WAIT: begin
            wb_alu     = hold_addr;
            wb_rd_addr = hold_rd;
            wb_signals = 3'b000;
            if (!timeout) begin
               dc_req   = 1'b1;
               dc_we    = hold_we;
               dc_addr  = hold_addr;
               dc_wdata = hold_wdata;
               if (dc_ready) begin
                  wb_signals = hold_wb;
                  wb_data    = hold_we ? 16'h0000 : dc_rdata;
               end else begin
                  mem_stall = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4): hit, miss load, store
// miss, watchdog timeout, asynchronous reset mid-miss and counter saturation.
module tb_mem_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_mem_read, ex_mem_write;
   logic [15:0] ex_alu, ex_store_data;
   logic [3:0]  ex_rd_addr;
   logic [2:0]  ex_wb_signals;
   logic        dc_req, dc_we;
   logic [15:0] dc_addr, dc_wdata, dc_rdata;
   logic        dc_ready;
   logic [15:0] wb_alu, wb_data;
   logic [3:0]  wb_rd_addr;
   logic [2:0]  wb_signals;
   logic        wb_we, mem_stall, err;
   logic [15:0] miss_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_stage_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_alu(ex_alu), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
      .ex_wb_signals(ex_wb_signals),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_rdata(dc_rdata), .dc_ready(dc_ready),
      .wb_alu(wb_alu), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
      .wb_signals(wb_signals), .wb_we(wb_we), .mem_stall(mem_stall),
      .err(err), .miss_count(miss_count)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
   endtask

   // Drive one EX/MEM instruction; kind: 0 none, 1 load, 2 store.
   task automatic drive(input int kind, input logic [15:0] a, input logic [15:0] d,
                        input logic [3:0] rd, input logic [2:0] wb);
      ex_valid      = (kind != 0);
      ex_mem_read   = (kind == 1);
      ex_mem_write  = (kind == 2);
      ex_alu        = a;
      ex_store_data = d;
      ex_rd_addr    = rd;
      ex_wb_signals = wb;
   endtask

   // Advance to the middle of the next cycle (inputs change on the falling edge).
   task automatic nxt();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      dc_ready = 1'b0;
      dc_rdata = 16'h0000;
      drive(0, 16'h0000, 16'h0000, 4'd0, 3'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dc_req", 16'(dc_req), 16'h0);
      chk("rst_stall", 16'(mem_stall), 16'h0);
      chk("rst_wb_we", 16'(wb_we), 16'h1);
      chk("rst_wb_sig", 16'(wb_signals), 16'h0);
      chk("rst_err", 16'(err), 16'h0);
      chk("rst_miss", miss_count, 16'h0);
      nxt();
      rst = 1'b0;

      // Hit load
      nxt();
      drive(1, 16'h0040, 16'h0000, 4'd5, 3'b101);
      dc_ready = 1'b1; dc_rdata = 16'hBEEF;
      #1;
      chk("hit_data", wb_data, 16'hBEEF);
      chk("hit_rd", 16'(wb_rd_addr), 16'h5);
      chk("hit_sig", 16'(wb_signals), 16'h5);
      chk("hit_stall", 16'(mem_stall), 16'h0);
      chk("hit_addr", dc_addr, 16'h0040);
      chk("hit_req", 16'(dc_req), 16'h1);
      nxt();
      chk("hit_miss", miss_count, 16'h0);

      // 3-cycle miss load: miss cycle + 2 waiting cycles stalled, ready on third WAIT cycle
      drive(1, 16'h1234, 16'h0000, 4'd7, 3'b011);
      dc_ready = 1'b0; dc_rdata = 16'h0000;
      #1;
      chk("ml_stall0", 16'(mem_stall), 16'h1);
      chk("ml_sig0", 16'(wb_signals), 16'h0);
      chk("ml_addr0", dc_addr, 16'h1234);
      nxt();
      drive(1, 16'hFFFF, 16'hAAAA, 4'd1, 3'b111);  // must be ignored while waiting
      #1;
      chk("ml_stall1", 16'(mem_stall), 16'h1);
      chk("ml_addr1", dc_addr, 16'h1234);
      chk("ml_we1", 16'(dc_we), 16'h0);
      chk("ml_sig1", 16'(wb_signals), 16'h0);
      nxt();
      #1;
      chk("ml_stall2", 16'(mem_stall), 16'h1);
      chk("ml_addr2", dc_addr, 16'h1234);
      nxt();
      dc_ready = 1'b1; dc_rdata = 16'h00A5;
      #1;
      chk("ml_stall3", 16'(mem_stall), 16'h0);
      chk("ml_data", wb_data, 16'h00A5);
      chk("ml_rd", 16'(wb_rd_addr), 16'h7);
      chk("ml_sig", 16'(wb_signals), 16'h3);
      chk("ml_alu", wb_alu, 16'h1234);
      chk("ml_miss", miss_count, 16'h1);
      nxt();
      dc_ready = 1'b0;
      drive(0, 16'h0000, 16'h0000, 4'd0, 3'd0);
      #1;
      chk("ml_idle_req", 16'(dc_req), 16'h0);
      chk("ml_idle_stall", 16'(mem_stall), 16'h0);

      // Store miss, ready on the first WAIT cycle
      nxt();
      drive(2, 16'h0010, 16'h5555, 4'd2, 3'b110);
      #1;
      chk("st_we0", 16'(dc_we), 16'h1);
      chk("st_wd0", dc_wdata, 16'h5555);
      chk("st_stall0", 16'(mem_stall), 16'h1);
      nxt();
      drive(0, 16'h0000, 16'h0000, 4'd0, 3'd0);
      dc_ready = 1'b1; dc_rdata = 16'h9999;
      #1;
      chk("st_we1", 16'(dc_we), 16'h1);
      chk("st_wd1", dc_wdata, 16'h5555);
      chk("st_addr1", dc_addr, 16'h0010);
      chk("st_data", wb_data, 16'h0000);
      chk("st_sig", 16'(wb_signals), 16'h6);
      chk("st_rd", 16'(wb_rd_addr), 16'h2);
      chk("st_stall1", 16'(mem_stall), 16'h0);
      chk("st_miss", miss_count, 16'h2);

      // Timeout: TIMEOUT=4, ready never comes
      nxt();
      dc_ready = 1'b0;
      drive(1, 16'h0200, 16'h0000, 4'd3, 3'b111);
      nxt();  // W1
      drive(0, 16'h0000, 16'h0000, 4'd0, 3'd0);
      nxt();  // W2
      nxt();  // W3
      #1;
      chk("to_w3_req", 16'(dc_req), 16'h1);
      chk("to_w3_stall", 16'(mem_stall), 16'h1);
      chk("to_w3_err", 16'(err), 16'h0);
      nxt();  // W4: abandon
      #1;
      chk("to_req", 16'(dc_req), 16'h0);
      chk("to_stall", 16'(mem_stall), 16'h0);
      chk("to_sig", 16'(wb_signals), 16'h0);
      chk("to_data", wb_data, 16'h0000);
      nxt();
      #1;
      chk("to_err", 16'(err), 16'h1);
      chk("to_idle_req", 16'(dc_req), 16'h0);
      chk("to_miss", miss_count, 16'h3);
      drive(1, 16'h0044, 16'h0000, 4'd9, 3'b001);
      dc_ready = 1'b1; dc_rdata = 16'h1357;
      #1;
      chk("to_hit_data", wb_data, 16'h1357);
      chk("to_hit_stall", 16'(mem_stall), 16'h0);
      nxt();
      chk("to_err_sticky", 16'(err), 16'h1);

      // Reset two cycles into a miss
      dc_ready = 1'b0;
      drive(1, 16'h0300, 16'h0000, 4'd4, 3'b010);
      nxt();  // W1
      drive(0, 16'h0000, 16'h0000, 4'd0, 3'd0);
      nxt();  // W2
      #1;
      chk("rm_req_before", 16'(dc_req), 16'h1);
      chk("rm_miss_before", miss_count, 16'h4);
      rst = 1'b1;
      #1;
      chk("rm_req", 16'(dc_req), 16'h0);
      chk("rm_stall", 16'(mem_stall), 16'h0);
      chk("rm_miss", miss_count, 16'h0);
      chk("rm_err", 16'(err), 16'h0);
      chk("rm_wb_we", 16'(wb_we), 16'h1);
      nxt();
      rst = 1'b0;

      // Saturation: preload the counter near the top, then two more misses
      nxt();
      force dut.miss_count = 16'hFFFE;
      #1;
      release dut.miss_count;
      for (int i = 0; i < 2; i++) begin
         nxt();
         dc_ready = 1'b0;
         drive(1, 16'h0500, 16'h0000, 4'd1, 3'b001);
         nxt();
         drive(0, 16'h0000, 16'h0000, 4'd0, 3'd0);
         dc_ready = 1'b1; dc_rdata = 16'h0001;
         nxt();
         dc_ready = 1'b0;
         chk(i == 0 ? "sat_ffff" : "sat_hold", miss_count, 16'hFFFF);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
